// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types, constants and note pitch table for the music sequencer
package music_pkg;

  localparam int NOTE_BITS = 4;
  localparam int END_DUR   = 0;

  typedef enum logic [1:0] {IDLE, LEAD, LOAD, PLAY} state_t;

  // C4 .. C6 major scale in Hz for note codes 1..15; code 0 is a rest
  function automatic int unsigned note_freq(input int unsigned code);
    case (code)
      1:  return 262;  2:  return 294;  3:  return 330;  4:  return 349;
      5:  return 392;  6:  return 440;  7:  return 494;  8:  return 523;
      9:  return 587;  10: return 659;  11: return 698;  12: return 784;
      13: return 880;  14: return 988;  15: return 1047;
      default: return 0;
    endcase
  endfunction

  // Half-period in clk cycles, never below 1 so slow test clocks still toggle
  function automatic logic [31:0] half_period(input int unsigned code, input int unsigned clk_hz);
    int unsigned f;
    int unsigned hp;
    f = note_freq(code);
    if (f == 0) return 32'd1;
    hp = clk_hz / (2 * f);
    return (hp == 0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/music_sequencer_tone_gen.sv
// rtl/music_sequencer_tone_gen.sv - 50% duty square wave for the current note code
module tone_gen
  import music_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int NOTE_W = NOTE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note,
  input  logic              en,
  output logic              tone_pwm
);

  logic [31:0]       half;
  logic [31:0]       cnt;
  logic [NOTE_W-1:0] note_q;
  logic              en_q;

  assign half = half_period(int'(note), CLK_HZ);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      tone_pwm <= 1'b0;
      note_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      note_q <= note;
      en_q   <= en;
      // restart the period so a new note always begins on a clean edge
      if ((note != note_q) || (en_q && !en)) begin
        cnt      <= '0;
        tone_pwm <= 1'b0;
      end else if (en) begin
        if (cnt >= half - 32'd1) begin
          cnt      <= '0;
          tone_pwm <= ~tone_pwm;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - multi-track event ROM sequencer driving the PWM amplifier
module music_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int N_TRACKS   = 4,
  parameter int ADDR_W     = 9,
  parameter int NOTE_W     = NOTE_BITS,
  parameter int DUR_W      = 20,
  parameter int LEAD_TICKS = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        play,
  input  logic [$clog2(N_TRACKS)-1:0] track,
  input  logic                        stop,
  input  logic                        pause,
  input  logic                        loop_en,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DUR_W+NOTE_W-1:0]     rom_data,
  output logic                        busy,
  output logic                        done,
  output logic                        note_en,
  output logic [NOTE_W-1:0]           note,
  output logic                        pwm,
  output logic                        sd
);

  localparam int TRK_W     = $clog2(N_TRACKS);
  localparam int OFF_W     = ADDR_W - TRK_W;
  localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;

  state_t            state;
  logic [TRK_W-1:0]  trk;
  logic [OFF_W-1:0]  off;
  logic [31:0]       presc;
  logic [31:0]       lead_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic              wrapped;
  logic              tick;
  logic              at_end;
  logic              tone_pwm;
  logic [DUR_W-1:0]  ev_dur;
  logic [NOTE_W-1:0] ev_note;

  assign ev_dur   = rom_data[DUR_W+NOTE_W-1:NOTE_W];
  assign ev_note  = rom_data[NOTE_W-1:0];
  // offset lives in its own field, so address arithmetic cannot leave the segment
  assign rom_addr = {trk, off};
  assign tick     = (presc == 32'(PRESC_MAX)) && !pause;
  assign at_end   = (state == LOAD) && ((ev_dur == DUR_W'(END_DUR)) || wrapped);
  assign done     = at_end && !loop_en && !pause && !stop && !play;
  assign busy     = (state != IDLE);
  assign note_en  = (state == PLAY) && (note != '0) && !pause;
  assign sd       = note_en;
  assign pwm      = tone_pwm & note_en;

  // prescaler also holds in LOAD so every event is exactly d ticks of PLAY
  always_ff @(posedge clk) begin
    if (rst || play)                   presc <= '0;
    else if (pause || state == LOAD)   presc <= presc;
    else if (presc == 32'(PRESC_MAX))  presc <= '0;
    else                               presc <= presc + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      trk      <= '0;
      off      <= '0;
      lead_cnt <= '0;
      dur_cnt  <= '0;
      note     <= '0;
      wrapped  <= 1'b0;
    end else if (stop) begin
      state   <= IDLE;
      note    <= '0;
      wrapped <= 1'b0;
    end else if (play) begin
      state    <= LEAD;
      trk      <= track;
      off      <= '0;
      lead_cnt <= '0;
      note     <= '0;
      wrapped  <= 1'b0;
    end else if (!pause) begin
      case (state)
        IDLE: ;
        LEAD: begin
          if (LEAD_TICKS == 0) begin
            state <= LOAD;
          end else if (tick) begin
            if (lead_cnt == 32'(LEAD_TICKS - 1)) begin
              state    <= LOAD;
              lead_cnt <= '0;
            end else begin
              lead_cnt <= lead_cnt + 32'd1;
            end
          end
        end
        LOAD: begin
          if (at_end) begin
            wrapped <= 1'b0;
            if (loop_en) begin
              off <= '0;
            end else begin
              state <= IDLE;
              note  <= '0;
            end
          end else begin
            note    <= ev_note;
            dur_cnt <= ev_dur;
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (dur_cnt == DUR_W'(1)) begin
              state   <= LOAD;
              off     <= off + 1'b1;
              wrapped <= &off;
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tone_gen #(.CLK_HZ(CLK_HZ), .NOTE_W(NOTE_W)) u_tone (
    .clk      (clk),
    .rst      (rst),
    .note     (note),
    .en       (note_en),
    .tone_pwm (tone_pwm)
  );

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Multi-track, parametrised event sequencer that plays note sequences from an event ROM and drives the on-board PWM audio amplifier. It sits between game-state control (start, stop, fail cues) and the speaker pins. Each track occupies a fixed ROM segment. Beyond the single-cue player it replaces, it adds duration-encoded events, track select, looping, pause, retrigger and a `done` pulse.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency
- `TICK_HZ`, 1000, sequencer time base (1 ms ticks)
- `N_TRACKS`, 4, number of tracks (power of two, ≥2)
- `ADDR_W`, 9, event ROM address width
- `NOTE_W`, 4, note code width; code 0 = rest
- `DUR_W`, 20, event duration width, in ticks
- `LEAD_TICKS`, 10, silent lead-in after `play`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `play`  in  1  single-cycle start/retrigger strobe
- `track`  in  $clog2(N_TRACKS)  track sampled on `play`
- `stop`  in  1  abort playback
- `pause`  in  1  level; freezes time while high
- `loop_en`  in  1  level; restart track at end marker
- `rom_addr`  out  ADDR_W  event ROM address, registered
- `rom_data`  in  DUR_W+NOTE_W  {dur, note}, asynchronous read of `rom_addr`
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on natural end of track
- `note_en`  out  1  tone active
- `note`  out  NOTE_W  current note code
- `pwm`  out  1  audio PWM
- `sd`  out  1  amplifier enable

## Operation
- Track segment size is S = 2^ADDR_W / N_TRACKS. The base address of track t is t·S.
- An event with `dur`==0 is the end marker. Reaching offset S−1 without a marker is also treated as end.
- Prescaler: counts 0 … CLK_HZ/TICK_HZ − 1 and emits a 1-cycle `tick` at wrap. It is cleared on `play` and holds while `pause`=1.
- States:
  - IDLE: `play` → LEAD. Latch the track, set `rom_addr`=base, clear the lead counter.
  - LEAD: count `LEAD_TICKS` ticks, then go to LOAD. If `LEAD_TICKS`=0, go to LOAD immediately.
  - LOAD: `rom_data` is valid this cycle.
    - `dur`==0 with `loop_en`=1: set `rom_addr`=base and stay in LOAD.
    - `dur`==0 with `loop_en`=0: pulse `done`, go to IDLE.
    - Otherwise: latch `note`, set `dur_cnt`=`dur`, go to PLAY.
  - PLAY: decrement `dur_cnt` on each tick. On the tick where `dur_cnt`==1, increment `rom_addr` and go to LOAD.
- Priority order: `rst` > `stop` > `play` > normal progression.
  - `stop` in any state → IDLE next cycle, `note_en`=0, no `done`.
  - `play` while busy restarts: the new track is latched and the sequencer enters LEAD. `done` does not fire.
  - `play` and `stop` in the same cycle: `stop` wins.
- `note_en` = (state==PLAY) & (`note`≠0) & ~`pause`. A rest keeps timing but stays silent.
- `pause` also freezes the lead and duration counters. State and `rom_addr` hold.
- `pwm` = `tone_pwm` & `note_en`; `sd` = `note_en`. Both are 0 outside PLAY.

## Timing
- Reset values: state IDLE, `rom_addr`=0, `busy`=0, `done`=0, `note_en`=0, `note`=0, `pwm`=0, `sd`=0. All counters are 0.
- `play` at cycle n: `busy`=1 and `rom_addr`=base at n+1.
- First `note_en` occurs 2 cycles after the lead-in ends (LEAD → LOAD → PLAY).
- An event of duration d lasts d ticks, plus 1 LOAD cycle, before the next event. The LOAD cycle is not compensated.
- End of track, no loop: `done` is high in the LOAD cycle that sees the marker. `busy` falls on the next cycle.
- Loop restart costs 1 extra LOAD cycle.
- `rom_addr` offset arithmetic wraps modulo S and never crosses into the next track's segment.
- `stop` or `rst` mid-note: outputs are silent on the next cycle.

## Structure
- Package `music_pkg`:
  - note code width constant
  - `state_t` enum {IDLE, LEAD, LOAD, PLAY}
  - half-period table for note codes 1–15 in clk cycles at `CLK_HZ` (C4 … C6 scale)
  - `END_DUR` = 0
- Sub-module `tone_gen`:
  - inputs `clk`, `rst`, `note`, `en`; output `tone_pwm`
  - square wave at 50 % duty
  - its period counter reloads when `note` changes or `en` falls
- The sequencer FSM, prescaler and counters are in `music_sequencer`.

## Test plan
- Reset, then idle 100 cycles → all outputs 0, `rom_addr`=0.
- Track 1 (base 128 for the default parameters), events {3,5},{2,0},{0,x}, `TICK_HZ`=CLK_HZ/10 → `note`=5 enabled for 30 cycles; then a silent rest of 20 cycles with `busy`=1; then one `done` pulse; then IDLE.
- Same track with `loop_en`=1 → address returns to 128 after the marker, no `done`, the pattern repeats 3 times.
- `pause` for 50 cycles mid-note → `note_en`=0 and `pwm`=0 during the pause; total note length extends by exactly 50 cycles.
- `play` with track 2 during track 0 → `rom_addr`=256 next cycle, no `done`. Then `stop` together with `play` → IDLE, `busy`=0.
- Segment with no end marker → wraps at offset S−1 and is treated as end: `done` when `loop_en`=0.
